// File: rtl/class_score_packer_pkg.sv
// Shared definitions for the classifier output path: state encoding and the
// shift-and-saturate requantizer used by every layer-output requantizer.
package class_score_packer_pkg;

    localparam logic COLLECT_ENC = 1'b0;
    localparam logic HOLD_ENC    = 1'b1;

    typedef enum logic {
        COLLECT = COLLECT_ENC,
        HOLD    = HOLD_ENC
    } state_e;

    // Working width of the requantizer; callers sign-extend into it and
    // truncate the result to their own output width.
    localparam int REQ_W = 64;

    function automatic logic [REQ_W-1:0] requant(
        input logic signed [REQ_W-1:0] acc,
        input int                      shift,
        input int                      bw
    );
        logic signed [REQ_W-1:0] q;
        logic signed [REQ_W-1:0] qmax;
        logic        [REQ_W-1:0] res;
        q    = acc >>> shift;
        qmax = $signed((REQ_W'(1) << bw) - REQ_W'(1));
        if (q < 0) begin
            res = '0;
        end else if (q > qmax) begin
            res = $unsigned(qmax);
        end else begin
            res = $unsigned(q);
        end
        return res;
    endfunction

endpackage

// File: rtl/class_score_packer_score_requant.sv
// Combinational requantizer: arithmetic right shift of a signed accumulator
// score followed by saturation to an unsigned BITWIDTH value.
module score_requant
    import class_score_packer_pkg::*;
#(
    parameter int ACC_WIDTH = 16,
    parameter int BITWIDTH  = 8,
    parameter int SHIFT     = 4
) (
    input  logic [ACC_WIDTH-1:0] acc_i,
    output logic [BITWIDTH-1:0]  q_o
);

    logic signed [REQ_W-1:0] acc_ext;

    assign acc_ext = {{(REQ_W-ACC_WIDTH){acc_i[ACC_WIDTH-1]}}, acc_i};
    assign q_o     = BITWIDTH'(requant(acc_ext, SHIFT, BITWIDTH));

endmodule

// File: rtl/class_score_packer.sv
// Collects CLASSES requantized scores into one vector and holds it for the
// softmax/argmax stage until that stage reports completion.
module class_score_packer
    import class_score_packer_pkg::*;
#(
    parameter int BITWIDTH  = 8,
    parameter int CLASSES   = 10,
    parameter int ACC_WIDTH = 16,
    parameter int SHIFT     = 4,
    parameter int CNT_WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ACC_WIDTH-1:0]         in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    output logic [BITWIDTH*CLASSES-1:0]  out_data,
    input  logic                         done_i,
    output logic                         err_o
);

    localparam int                   VEC_W     = BITWIDTH * CLASSES;
    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(CLASSES - 1);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [VEC_W-1:0]     data_q, data_d;
    logic                 err_q, err_d;
    logic                 live_q;
    logic [BITWIDTH-1:0]  score;
    logic                 accept;

    score_requant #(
        .ACC_WIDTH (ACC_WIDTH),
        .BITWIDTH  (BITWIDTH),
        .SHIFT     (SHIFT)
    ) u_requant (
        .acc_i (in_data),
        .q_o   (score)
    );

    // live_q keeps in_ready low until the first clock after reset release.
    assign in_ready  = live_q && (state_q == COLLECT);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == HOLD);
    assign out_data  = data_q;
    assign err_o     = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            COLLECT: begin
                if (accept) begin
                    data_d[cnt_q*BITWIDTH +: BITWIDTH] = score;
                    if (cnt_q == LAST_BEAT) begin
                        // A full frame is held even when in_last is missing.
                        err_d   = err_q | ~in_last;
                        state_d = HOLD;
                        cnt_d   = '0;
                    end else if (in_last) begin
                        err_d  = 1'b1;
                        cnt_d  = '0;
                        data_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            HOLD: begin
                if (done_i) begin
                    state_d = COLLECT;
                    data_d  = '0;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
            live_q  <= 1'b1;
        end
    end

endmodule
